uart_rx_ext: RTL and testbench

Second-generation UART receiver for the serial IP: recovers frames from the asynchronous `rx` line using the shared baud generator's oversampling `tick`. Data width, parity mode and stop-bit count are selectable at run time. Each bit is decided by a 3-sample majority vote, false start bits are rejected, and break conditions are detected. Received words are handed to the host over a valid/ready interface with overrun reporting.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_ext.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_rx_ext receiver.
// FSM states, parity/data-bits codes and the 2-of-3 vote.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_t;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;

  typedef struct packed {
    logic [1:0] data_bits;
    logic [1:0] parity;
    logic       stop2;
  } rx_cfg_t;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO for uart_rx_ext.
// Show-ahead read from the flop array; push+pop when full is legal.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      cnt;
  logic             wr;
  logic             rd;

  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  assign dout  = mem[rp];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver: majority-vote sampling, parity, break, overrun.
// Define UART_RX_FIFO_EN to replace the holding register with a FIFO.
module uart_rx_ext #(
  parameter int OVERSAMPLE  = 16,
  parameter int MAX_DATA_WD = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   rx,
  input  logic                   rx_en,
  input  logic [1:0]             cfg_data_bits,
  input  logic [1:0]             cfg_parity,
  input  logic                   cfg_stop2,
  output logic [MAX_DATA_WD-1:0] dout,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_error,
  output logic                   framing_error,
  output logic                   break_detect,
  output logic                   overrun,
  output logic                   rx_busy
);
  import uart_pkg::*;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int W  = MAX_DATA_WD + 3;
  localparam logic [CW-1:0] C_S0  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] C_S1  = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] C_S2  = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] C_MAX = CW'(OVERSAMPLE - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx_ext: illegal OVERSAMPLE or FIFO_DEPTH");
  end

  rx_state_t state, state_n;
  rx_cfg_t   cfg_q;

  logic                   rx_s1, rxs, rxs_d;
  logic [CW-1:0]          cnt;
  logic [1:0]             smp;
  logic [2:0]             bit_idx;
  logic                   stop_idx;
  logic [MAX_DATA_WD-1:0] sr;
  logic                   par_bit;
  logic                   pe_q, fe_q, brk_q;

  logic       fall, dec, bit_end, bit_v;
  logic       par_en, par_exp, brk_now;
  logic       brk_fin, fe_fin;
  logic [2:0] last_idx;
  logic       start, done;
  logic [W-1:0] word, out_w;
  logic       valid_w, ovr_q;

  assign fall     = rxs_d & ~rxs;
  assign dec      = tick & (cnt == C_S2);
  assign bit_end  = tick & (cnt == C_MAX);
  assign bit_v    = maj3({rxs, smp});
  assign last_idx = {1'b0, cfg_q.data_bits} + 3'd4;
  assign par_en   = (cfg_q.parity == PAR_ODD) |
                    (cfg_q.parity == PAR_EVEN);
  assign par_exp  = (cfg_q.parity == PAR_ODD) ? ~^sr : ^sr;
  assign brk_now  = (sr == '0) & (~par_en | ~par_bit) & ~bit_v;
  assign brk_fin  = cfg_q.stop2 ? brk_q : brk_now;
  assign fe_fin   = fe_q | ~bit_v;
  assign word     = {pe_q, fe_fin, brk_fin, sr};

  always_comb begin
    state_n = state;
    start   = 1'b0;
    done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_en && fall) begin
          state_n = S_START;
          start   = 1'b1;
        end
      end
      S_START: begin
        if (dec && bit_v)  state_n = S_IDLE;
        else if (bit_end)  state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx == last_idx)
          state_n = par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_n = S_STOP;
      end
      S_STOP: begin
        // frame ends at the vote of the last stop bit, not its end
        if (dec && (stop_idx || !cfg_q.stop2)) begin
          done    = 1'b1;
          state_n = brk_fin ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: begin
        if (rxs) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_d    <= 1'b1;
      state    <= S_IDLE;
      cfg_q    <= '0;
      cnt      <= '0;
      smp      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      sr       <= '0;
      par_bit  <= 1'b0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      rxs_d <= rxs;
      state <= state_n;
      if (start)     cnt <= '0;
      else if (tick) cnt <= (cnt == C_MAX) ? '0 : cnt + 1'b1;
      if (tick && cnt == C_S0) smp[1] <= rxs;
      if (tick && cnt == C_S1) smp[0] <= rxs;
      if (start) begin
        cfg_q    <= '{cfg_data_bits, cfg_parity, cfg_stop2};
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        sr       <= '0;
        par_bit  <= 1'b0;
        pe_q     <= 1'b0;
        fe_q     <= 1'b0;
        brk_q    <= 1'b0;
      end
      if (state == S_DATA) begin
        if (dec)     sr[bit_idx] <= bit_v;
        if (bit_end) bit_idx <= bit_idx + 1'b1;
      end
      if (state == S_PARITY && dec) begin
        par_bit <= bit_v;
        pe_q    <= (bit_v != par_exp);
      end
      if (state == S_STOP) begin
        if (dec && !stop_idx) begin
          fe_q  <= ~bit_v;
          brk_q <= brk_now;
        end
        if (bit_end) stop_idx <= 1'b1;
      end
    end
  end

`ifdef UART_RX_FIFO_EN
  logic full, empty, pop;

  assign pop     = ~empty & rx_ready;
  assign valid_w = ~empty;

  uart_rx_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done),
    .pop   (pop),
    .din   (word),
    .dout  (out_w),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) ovr_q <= 1'b0;
    else     ovr_q <= done & full & ~pop;
  end
`else
  logic [W-1:0] hold;
  logic         hold_v;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold   <= '0;
      hold_v <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (hold_v && rx_ready) hold_v <= 1'b0;
      if (done) begin
        if (!hold_v || rx_ready) begin
          hold   <= word;
          hold_v <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign out_w   = hold;
  assign valid_w = hold_v;
`endif

  assign parity_error  = out_w[W-1];
  assign framing_error = out_w[W-2];
  assign break_detect  = out_w[W-3];
  assign dout          = out_w[MAX_DATA_WD-1:0];
  assign rx_valid      = valid_w;
  assign overrun       = ovr_q;
  assign rx_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Scenario bench for uart_rx_ext with an expected-word queue.
// Define UART_RX_FIFO_EN to exercise the FIFO build.
module tb_uart_rx_ext;

  localparam int OS   = 16;
  localparam int TDIV = 2;
  localparam int BIT  = OS * TDIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_en = 1'b1;
  logic [1:0] cfg_data_bits = 2'b11;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic [7:0] dout;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       parity_error, framing_error, break_detect;
  logic       overrun, rx_busy;

  uart_rx_ext #(
    .OVERSAMPLE  (OS),
    .MAX_DATA_WD (8),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .rx            (rx),
    .rx_en         (rx_en),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .dout          (dout),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .break_detect  (break_detect),
    .overrun       (overrun),
    .rx_busy       (rx_busy)
  );

  always #5 clk = ~clk;

  int tdc = 0;
  always @(posedge clk) begin
    tick <= (tdc == TDIV - 1);
    tdc  <= (tdc == TDIV - 1) ? 0 : tdc + 1;
  end

  typedef struct {
    logic [7:0] d;
    logic pe, fe, brk;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   passed = 0;
  int   total = 0;
  int   ovr_cnt = 0;
  int   vrise = 0;
  logic v_d = 1'b0;

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready)
      got_q.push_back('{d: dout, pe: parity_error,
                        fe: framing_error, brk: break_detect});
    if (!rst && overrun) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid && !v_d) vrise <= vrise + 1;
    v_d <= rx_valid;
  end

  task automatic drive(input logic v, input int n, input bit spk);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rx = (spk && c >= 16 && c < 18) ? ~v : v;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nb,
                            input int par, input bit s2,
                            input bit flip, input int spike);
    logic [7:0] m;
    logic p;
    m = d;
    for (int i = nb; i < 8; i++) m[i] = 1'b0;
    p = (par == 1) ? ~^m : ^m;
    drive(1'b0, BIT, 1'b0);
    for (int i = 0; i < nb; i++) drive(m[i], BIT, i == spike);
    if (par != 0) drive(p ^ flip, BIT, 1'b0);
    drive(1'b1, s2 ? 2 * BIT : BIT, 1'b0);
    drive(1'b1, BIT, 1'b0);
  endtask

  task automatic get_word(output rec_t r, output bit ok);
    for (int k = 0; k < 4 * BIT && got_q.size() == 0; k++)
      @(negedge clk);
    ok = (got_q.size() != 0);
    if (ok) r = got_q.pop_front();
    else    r = '{8'h00, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (dout !== 8'h00)
      $display("FAIL rst_dout got=%h want=00", dout);
    else passed++;
    total++;
    if (rx_valid !== 1'b0)
      $display("FAIL rst_valid got=%b want=0", rx_valid);
    else passed++;
    total++;
    if ({parity_error, framing_error, break_detect} !== 3'b000)
      $display("FAIL rst_flags got=%b want=000",
               {parity_error, framing_error, break_detect});
    else passed++;
    total++;
    if ({overrun, rx_busy} !== 2'b00)
      $display("FAIL rst_ovr_busy got=%b want=00", {overrun, rx_busy});
    else passed++;
    rst = 1'b0;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic test_8n1;
    rec_t e, g;
    bit ok;
    int v0;
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    v0 = vrise;
    exp_q.push_back('{8'hA5, 1'b0, 1'b0, 1'b0});
    send_frame(8'hA5, 8, 0, 1'b0, 1'b0, -1);
    get_word(g, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {g.d, g.pe, g.fe, g.brk} !== {e.d, e.pe, e.fe, e.brk})
      $display("FAIL 8n1_word got=%h/%b%b%b want=%h/%b%b%b ok=%0d",
               g.d, g.pe, g.fe, g.brk, e.d, e.pe, e.fe, e.brk, ok);
    else passed++;
    total++;
    if (vrise - v0 !== 1)
      $display("FAIL 8n1_valid_pulses got=%0d want=1", vrise - v0);
    else passed++;
    total++;
    if ({rx_valid, rx_busy} !== 2'b00)
      $display("FAIL 8n1_idle got=%b want=00", {rx_valid, rx_busy});
    else passed++;
  endtask

  task automatic test_7e2;
    rec_t e, g;
    bit ok;
    cfg_data_bits = 2'b10; cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back('{8'h3C, f == 1, 1'b0, 1'b0});
      send_frame(8'h3C, 7, 2, 1'b1, f == 1, -1);
      get_word(g, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || {g.d, g.pe, g.fe, g.brk} !== {e.d, e.pe, e.fe, e.brk})
        $display("FAIL 7e2_word%0d got=%h/%b%b%b want=%h/%b%b%b ok=%0d",
                 f, g.d, g.pe, g.fe, g.brk, e.d, e.pe, e.fe, e.brk, ok);
      else passed++;
    end
  endtask

  task automatic test_glitch;
    rec_t e, g;
    bit ok;
    int v0;
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    v0 = vrise;
    drive(1'b0, (BIT * 4) / 10, 1'b0);
    total++;
    if (rx_busy !== 1'b1)
      $display("FAIL glitch_busy_rise got=%b want=1", rx_busy);
    else passed++;
    drive(1'b1, BIT, 1'b0);
    total++;
    if (rx_busy !== 1'b0 || vrise != v0)
      $display("FAIL glitch_reject busy=%b words=%0d want busy=0 words=0",
               rx_busy, vrise - v0);
    else passed++;
    exp_q.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    send_frame(8'h5A, 8, 0, 1'b0, 1'b0, 3);
    get_word(g, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {g.d, g.pe, g.fe, g.brk} !== {e.d, e.pe, e.fe, e.brk})
      $display("FAIL spike_word got=%h/%b%b%b want=%h/%b%b%b ok=%0d",
               g.d, g.pe, g.fe, g.brk, e.d, e.pe, e.fe, e.brk, ok);
    else passed++;
  endtask

  task automatic test_break;
    rec_t e, g;
    bit ok;
    cfg_data_bits = 2'b11; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    exp_q.push_back('{8'h00, 1'b1, 1'b1, 1'b1});
    drive(1'b0, 20 * BIT, 1'b0);
    get_word(g, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {g.d, g.fe, g.brk} !== {e.d, e.fe, e.brk})
      $display("FAIL break_word got=%h fe=%b brk=%b want=%h fe=%b brk=%b",
               g.d, g.fe, g.brk, e.d, e.fe, e.brk);
    else passed++;
    total++;
    if (rx_busy !== 1'b1 || got_q.size() != 0)
      $display("FAIL break_hold busy=%b extra=%0d want busy=1 extra=0",
               rx_busy, got_q.size());
    else passed++;
    drive(1'b1, 8, 1'b0);
    total++;
    if (rx_busy !== 1'b0)
      $display("FAIL break_release got=%b want=0", rx_busy);
    else passed++;
    drive(1'b1, BIT, 1'b0);
    exp_q.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
    send_frame(8'h55, 8, 1, 1'b0, 1'b0, -1);
    get_word(g, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {g.d, g.pe, g.fe, g.brk} !== {e.d, e.pe, e.fe, e.brk})
      $display("FAIL after_break got=%h/%b%b%b want=%h/%b%b%b ok=%0d",
               g.d, g.pe, g.fe, g.brk, e.d, e.pe, e.fe, e.brk, ok);
    else passed++;
  endtask

  task automatic test_overrun;
    rec_t e, g;
    bit ok;
    int o0;
    int nsend;
    int nkeep;
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    set_ready(1'b0);
    o0 = ovr_cnt;
`ifdef UART_RX_FIFO_EN
    nsend = 5; nkeep = 4;
`else
    nsend = 2; nkeep = 1;
`endif
    for (int i = 0; i < nsend; i++) begin
      if (i < nkeep) exp_q.push_back('{8'(8'h11 * (i + 1)), 1'b0, 1'b0, 1'b0});
      send_frame(8'(8'h11 * (i + 1)), 8, 0, 1'b0, 1'b0, -1);
    end
    total++;
    if (ovr_cnt - o0 !== 1)
      $display("FAIL ovr_pulses got=%0d want=1", ovr_cnt - o0);
    else passed++;
    total++;
    if (rx_valid !== 1'b1 || dout !== 8'h11)
      $display("FAIL ovr_hold valid=%b dout=%h want valid=1 dout=11",
               rx_valid, dout);
    else passed++;
    set_ready(1'b1);
    for (int i = 0; i < nkeep; i++) begin
      get_word(g, ok);
      e = exp_q.pop_front();
      total++;
      if (!ok || {g.d, g.pe, g.fe, g.brk} !== {e.d, e.pe, e.fe, e.brk})
        $display("FAIL ovr_drain%0d got=%h/%b%b%b want=%h/%b%b%b ok=%0d",
                 i, g.d, g.pe, g.fe, g.brk, e.d, e.pe, e.fe, e.brk, ok);
      else passed++;
    end
    repeat (8) @(negedge clk);
    total++;
    if (rx_valid !== 1'b0 || got_q.size() != 0)
      $display("FAIL ovr_empty valid=%b extra=%0d want valid=0 extra=0",
               rx_valid, got_q.size());
    else passed++;
  endtask

  task automatic test_reset_mid;
    rec_t e, g;
    bit ok;
    logic [7:0] d;
    cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    d = 8'hF0;
    drive(1'b0, BIT, 1'b0);
    for (int i = 0; i < 4; i++) drive(d[i], BIT, 1'b0);
    total++;
    if (rx_busy !== 1'b1)
      $display("FAIL mid_busy got=%b want=1", rx_busy);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    total++;
    if ({dout, rx_valid, parity_error, framing_error, break_detect,
         overrun, rx_busy} !== 14'h0)
      $display("FAIL mid_reset got=%h/%b%b%b%b%b%b want=00/000000",
               dout, rx_valid, parity_error, framing_error,
               break_detect, overrun, rx_busy);
    else passed++;
    rst = 1'b0;
    drive(1'b1, 2 * BIT, 1'b0);
    total++;
    if (got_q.size() != 0 || rx_busy !== 1'b0)
      $display("FAIL mid_discard words=%0d busy=%b want 0/0",
               got_q.size(), rx_busy);
    else passed++;
    exp_q.push_back('{8'h0F, 1'b0, 1'b0, 1'b0});
    send_frame(8'h0F, 8, 0, 1'b0, 1'b0, -1);
    get_word(g, ok);
    e = exp_q.pop_front();
    total++;
    if (!ok || {g.d, g.pe, g.fe, g.brk} !== {e.d, e.pe, e.fe, e.brk})
      $display("FAIL after_reset got=%h/%b%b%b want=%h/%b%b%b ok=%0d",
               g.d, g.pe, g.fe, g.brk, e.d, e.pe, e.fe, e.brk, ok);
    else passed++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_8n1;
    test_7e2;
    test_glitch;
    test_break;
    test_overrun;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
